// File: rtl/spi_master_core.sv
// spi_master_core: full-duplex SPI master engine, one transfer per accepted strobe.
//
// Parameters
//   DATA_W  bits per transfer (>= 2)
//   NUM_SS  number of active-low slave selects (>= 1)
//   DIV_W   width of clk_div
//   SS_W    width of the binary slave index (derived from NUM_SS by default)
//
// Ports
//   clk, rst       system clock (rising edge) and asynchronous active-high reset
//   toXmit         word to send, sampled on an accepted strobe
//   strobe         start request, accepted only while idle (including the Ready cycle)
//   ss             binary slave index; values >= NUM_SS select no slave
//   cpol, cpha     SPI mode, sampled on an accepted strobe
//   clk_div        sck half-period = clk_div + 1 clk cycles, sampled on an accepted strobe
//   Rcvd           last received word, updated only at completion
//   Ready          single-cycle completion pulse
//   busy           high from accepted strobe until the Ready cycle (exclusive)
//   sck, mosi      SPI clock and serial data out
//   miso           serial data in, sampled directly (no synchroniser)
//   ss_n           one-hot active-low slave selects
//
// Optional feature
//   SPI_MASTER_LSB_FIRST_EN: when defined, adds input lsb_first (sampled on an accepted
//   strobe) selecting LSB-first transmit and receive. Undefined: always MSB-first.

module spi_master_core #(
   parameter int DATA_W = 8,
   parameter int NUM_SS = 2,
   parameter int DIV_W  = 8,
   parameter int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] toXmit,
   input  logic              strobe,
   input  logic [SS_W-1:0]   ss,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [DIV_W-1:0]  clk_div,
   output logic [DATA_W-1:0] Rcvd,
   output logic              Ready,
   output logic              busy,
   output logic              sck,
   output logic              mosi,
   input  logic              miso,
`ifdef SPI_MASTER_LSB_FIRST_EN
   input  logic              lsb_first,
`endif
   output logic [NUM_SS-1:0] ss_n
);

   localparam int CNT_W = $clog2(2 * DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_EDGE    = CNT_W'(2 * DATA_W);
   localparam logic [CNT_W-1:0] LAST_EDGE_M1 = CNT_W'(2 * DATA_W - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

   state_e              state_q, state_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [DIV_W-1:0]    tick_q, tick_d;
   logic [CNT_W-1:0]    edge_q, edge_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic                cpol_q, cpol_d;
   logic                cpha_q, cpha_d;
   logic                lsb_q, lsb_d;

   logic [DATA_W-1:0]   rcvd_d;
   logic                ready_d, busy_d, sck_d, mosi_d;
   logic [NUM_SS-1:0]   ss_n_d;

   logic [NUM_SS-1:0]   sel;
   logic [DATA_W-1:0]   tx_shift;
   logic [DATA_W-1:0]   rx_shift;
   logic                tx_next_bit;
   logic                lsb_in;
   logic                expire;
   logic                leading;
   logic                shift_ok;

`ifdef SPI_MASTER_LSB_FIRST_EN
   assign lsb_in = lsb_first;
`else
   assign lsb_in = 1'b0;
`endif

   // Decode the binary slave index; out-of-range indices leave every line deasserted.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_SS; i++) begin
         sel[i] = (int'(ss) == i);
      end
   end

   always_comb begin
      tx_shift    = lsb_q ? (tx_q >> 1) : (tx_q << 1);
      tx_next_bit = lsb_q ? tx_shift[0] : tx_shift[DATA_W-1];
      rx_shift    = lsb_q ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
   end

   // edge_q counts sck edges already driven, so the edge about to be driven is odd
   // (leading) when edge_q is even.
   assign expire  = (tick_q == div_q);
   assign leading = ~edge_q[0];
   // CPHA=0 never shifts after the final edge; CPHA=1 drives the MSB on the first
   // leading edge without shifting.
   assign shift_ok = cpha_q ? (edge_q != '0) : (edge_q != LAST_EDGE_M1);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      tick_d  = tick_q;
      edge_d  = edge_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      lsb_d   = lsb_q;
      rcvd_d  = Rcvd;
      ready_d = 1'b0;
      busy_d  = busy;
      sck_d   = sck;
      mosi_d  = mosi;
      ss_n_d  = ss_n;

      unique case (state_q)
         StIdle: begin
            sck_d = cpol;
            if (strobe) begin
               state_d = StSetup;
               tick_d  = '0;
               edge_d  = '0;
               div_d   = clk_div;
               cpol_d  = cpol;
               cpha_d  = cpha;
               lsb_d   = lsb_in;
               tx_d    = toXmit;
               rx_d    = '0;
               mosi_d  = lsb_in ? toXmit[0] : toXmit[DATA_W-1];
               ss_n_d  = ~sel;
               busy_d  = 1'b1;
            end
         end

         // SETUP is the first half-period; SHIFT covers every edge plus the
         // half-period that follows the last one.
         StSetup, StShift: begin
            tick_d = tick_q + DIV_W'(1);
            if (expire) begin
               tick_d = '0;
               if (edge_q == LAST_EDGE) begin
                  state_d = StHold;
               end else begin
                  state_d = StShift;
                  edge_d  = edge_q + CNT_W'(1);
                  sck_d   = leading ? ~cpol_q : cpol_q;
                  if (leading ^ cpha_q) begin
                     rx_d = rx_shift;
                  end else if (shift_ok) begin
                     tx_d   = tx_shift;
                     mosi_d = tx_next_bit;
                  end
               end
            end
         end

         StHold: begin
            tick_d = tick_q + DIV_W'(1);
            if (expire) begin
               state_d = StIdle;
               tick_d  = '0;
               sck_d   = cpol_q;
               ss_n_d  = '1;
               busy_d  = 1'b0;
               ready_d = 1'b1;
               rcvd_d  = rx_q;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         div_q   <= '0;
         tick_q  <= '0;
         edge_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         lsb_q   <= 1'b0;
         Rcvd    <= '0;
         Ready   <= 1'b0;
         busy    <= 1'b0;
         sck     <= 1'b0;
         mosi    <= 1'b0;
         ss_n    <= '1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         tick_q  <= tick_d;
         edge_q  <= edge_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         lsb_q   <= lsb_d;
         Rcvd    <= rcvd_d;
         Ready   <= ready_d;
         busy    <= busy_d;
         sck     <= sck_d;
         mosi    <= mosi_d;
         ss_n    <= ss_n_d;
      end
   end

endmodule

// File: doc/spi_master_core.md
# spi_master_core

Parametrised, full-duplex SPI master engine driving the master side of the SPI bus (`sck`, `mosi`, `miso`, slave selects) from the system-side control handshake (`toXmit`/`strobe`/`Rcvd`/`Ready`). It extends the fixed 8-bit, two-slave arrangement in three ways:
- data width and slave count are parameters;
- all four CPOL/CPHA modes are supported;
- the `sck` rate is programmable.

One transfer runs per strobe; the word received on `miso` is returned through `Rcvd` with a one-cycle `Ready` pulse.

## Interface
Parameters:
- `DATA_W`, 8 — bits per transfer (≥2).
- `NUM_SS`, 2 — number of slave-select lines (≥1).
- `DIV_W`, 8 — width of clock-divider input.
- `SS_W`, `$clog2(NUM_SS)` (min 1) — width of slave index (derived).

Ports:
- `clk` in 1 — system clock, all logic on rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `toXmit` in `DATA_W` — word to transmit, sampled on accepted strobe.
- `strobe` in 1 — start request, accepted only in IDLE.
- `ss` in `SS_W` — binary index of slave to select, sampled on accepted strobe.
- `cpol` in 1 — sck idle level, sampled on accepted strobe.
- `cpha` in 1 — phase, sampled on accepted strobe.
- `clk_div` in `DIV_W` — half-period of sck = `clk_div`+1 clk cycles, sampled on accepted strobe.
- `Rcvd` out `DATA_W` — last received word, held until next Ready.
- `Ready` out 1 — one-cycle pulse: transfer done, `Rcvd` valid.
- `busy` out 1 — high from accepted strobe until Ready cycle (exclusive).
- `sck` out 1 — SPI clock.
- `mosi` out 1 — serial data out.
- `miso` in 1 — serial data in.
- `ss_n` out `NUM_SS` — active-low one-hot slave selects.

## Operation
- Reset values:
  - `ss_n` all ones.
  - `sck`, `mosi`, `Ready`, `busy` 0.
  - `Rcvd` 0.
  - State IDLE.
- States:
  - **IDLE**: `sck` = registered `cpol` input. On `strobe`, latch `toXmit` into shift register, latch `ss`/`cpol`/`cpha`/`clk_div`, go to SETUP.
  - **SETUP**: one half-period H=`clk_div`+1. Selected `ss_n` bit low; `mosi` = MSB.
  - **SHIFT**: 2·`DATA_W` sck edges, one per H cycles.
    - Leading edge = transition away from CPOL.
    - CPHA=0: sample `miso` on leading edge; shift out next bit on trailing edge (no shift after final edge).
    - CPHA=1: drive next bit on leading edge (first leading edge drives MSB); sample on trailing edge.
  - **HOLD**: H cycles, `sck` at CPOL, `ss_n` still asserted.
  - **DONE**: then IDLE with `ss_n` all ones, `Rcvd` loaded, `Ready`=1 for that single cycle.
- Received bits are shifted in MSB-first (default); `Rcvd` is updated only at completion.
- `strobe` while busy: ignored, no queuing.
- `strobe` in the Ready cycle: accepted (back-to-back transfers allowed).
- `ss` ≥ `NUM_SS`: transfer runs normally; no `ss_n` line asserted.
- `rst` mid-transfer: immediate return to reset values. No Ready is generated and `Rcvd` is cleared.
- Changes to `cpol`/`cpha`/`clk_div` during a transfer have no effect until the next accepted strobe.

## Timing
- Strobe accepted at edge 0 → `ss_n` low, `mosi` = MSB, `busy` = 1 from cycle 1.
- First sck edge at cycle 1+H; successive edges every H cycles.
- `Ready` high in cycle 1+(2·`DATA_W`+2)·H; `ss_n` deasserts and `busy` drops in the same cycle.
- Example: `DATA_W`=8, `clk_div`=0 → Ready at cycle 19. With `clk_div`=3 → Ready at cycle 73.
- `miso` is sampled by `clk` at the cycle the sck edge is driven; no input synchroniser.

## Configuration
- `SPI_MASTER_LSB_FIRST_EN`:
  - Defined: adds input port `lsb_first` (1 bit), sampled on accepted strobe. When 1, transmit and receive are LSB-first, and `mosi` in SETUP is bit 0.
  - Undefined: port absent, always MSB-first.

## Test plan
- Mode 0, `DATA_W`=8, `clk_div`=0, `ss`=1, `toXmit`=0xA5, slave model returns 0x3C → `mosi` bits 1,0,1,0,0,1,0,1; `ss_n`=2'b01 during transfer; Ready at cycle 19 with `Rcvd`=0x3C.
- All four modes, `clk_div`=2, `toXmit`=0x81, loopback `miso`=`mosi` → `Rcvd`=0x81 each time. `sck` idles at CPOL and shows exactly 8 pulses of 6-cycle period.
- Back-to-back: strobe 0x12, hold `strobe` high, present 0x34 in the Ready cycle → second transfer accepted; strobes in between ignored; two Ready pulses 19 cycles apart.
- Reset asserted at cycle 7 of a transfer → `ss_n`=all ones, `sck`=0, `busy`=0, `Rcvd`=0 immediately; no Ready pulse.
- `ss`=3 with `NUM_SS`=2 → full-length transfer, `ss_n` stays 2'b11, Ready still pulses.
- With `SPI_MASTER_LSB_FIRST_EN`, `lsb_first`=1, `toXmit`=0x01, loopback → first `mosi` bit 1, `Rcvd`=0x01.
